// File: rtl/controller.sv
// controller: eight-phase sequencing FSM for the 8-bit RISC core; `CTRL_STEP_EN adds a single-step input
module controller #(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef CTRL_STEP_EN
  input  logic       step,
`endif
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       halt,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr
);
  localparam logic [3:0] INST_ADDR  = 4'd0;
  localparam logic [3:0] INST_FETCH = 4'd1;
  localparam logic [3:0] INST_LOAD  = 4'd2;
  localparam logic [3:0] IDLE       = 4'd3;
  localparam logic [3:0] OP_ADDR    = 4'd4;
  localparam logic [3:0] OP_FETCH   = 4'd5;
  localparam logic [3:0] ALU_OP     = 4'd6;
  localparam logic [3:0] STORE      = 4'd7;
  localparam logic [3:0] HALTED     = 4'd8;
  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;
  logic [3:0] s, nxt;
  logic go, alu_op, is_sto, is_jmp;
`ifdef CTRL_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif
  assign alu_op = opcode >= 3'd2 && opcode <= 3'd5;
  assign is_sto = opcode == STO;
  assign is_jmp = opcode == JMP;
  // ring phases 1..6 (except OP_ADDR) simply count up; STORE and unused codes return to INST_ADDR
  always_comb begin
    nxt = s == INST_ADDR ? (go ? INST_FETCH : INST_ADDR)
        : s == OP_ADDR   ? (HALT_STICKY && opcode == HLT ? HALTED : OP_FETCH)
        : s == HALTED    ? HALTED
        : s <  STORE     ? s + 4'd1
        : INST_ADDR;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= INST_ADDR;
    else        s <= nxt;
  assign sel    = s <= IDLE;
  assign rd     = (s >= INST_FETCH && s <= IDLE) || (alu_op && s >= OP_FETCH && s <= STORE);
  assign ld_ir  = s == INST_LOAD || s == IDLE;
  assign inc_pc = s == OP_ADDR || (s == ALU_OP && opcode == SKZ && zero);
  assign ld_pc  = is_jmp && (s == ALU_OP || s == STORE);
  assign halt   = (s == OP_ADDR && opcode == HLT) || s == HALTED;
  assign data_e = is_sto && (s == ALU_OP || s == STORE);
  assign ld_ac  = alu_op && s == STORE;
  assign wr     = is_sto && s == STORE;
endmodule

// File: tb/tb_controller.sv
// tb_controller: scoreboard bench running sticky and non-sticky halt variants against a phase-table model
module tb_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic zero = 1'b0;
  logic step = 1'b1;
  logic s1, r1, i1, n1, l1, h1, d1, a1, w1;
  logic s0, r0, i0, n0, l0, h0, d0, a0, w0;
  logic [8:0] v1, v0;
  logic [8:0] q1[$], q0[$];
  int p1 = 0, p0 = 0;
  int vec = 0, err = 0;
  always #5 clk = ~clk;
  controller #(.HALT_STICKY(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
`ifdef CTRL_STEP_EN
    .step(step),
`endif
    .sel(s1), .rd(r1), .ld_ir(i1), .inc_pc(n1), .ld_pc(l1), .halt(h1), .data_e(d1), .ld_ac(a1), .wr(w1));
  controller #(.HALT_STICKY(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
`ifdef CTRL_STEP_EN
    .step(step),
`endif
    .sel(s0), .rd(r0), .ld_ir(i0), .inc_pc(n0), .ld_pc(l0), .halt(h0), .data_e(d0), .ld_ac(a0), .wr(w0));
  assign v1 = {s1, r1, i1, n1, l1, h1, d1, a1, w1};
  assign v0 = {s0, r0, i0, n0, l0, h0, d0, a0, w0};
  // phase index 0..7 follows the instruction ring, 8 is the halted state
  function automatic logic [8:0] model(input int p, input logic [2:0] op, input logic z);
    logic alu;
    alu = op >= 3'd2 && op <= 3'd5;
    case (p)
      0: return 9'b100000000;
      1: return 9'b110000000;
      2, 3: return 9'b111000000;
      4: return {4'b0001, 1'b0, op == 3'd0, 3'b000};
      5: return {1'b0, alu, 7'b0};
      6: return {1'b0, alu, 1'b0, op == 3'd1 && z, op == 3'd7, 1'b0, op == 3'd6, 2'b00};
      7: return {1'b0, alu, 2'b00, op == 3'd7, 1'b0, op == 3'd6, alu, op == 3'd6};
      default: return 9'b000001000;
    endcase
  endfunction
  function automatic int next_phase(input int p, input logic [2:0] op, input bit sticky);
    if (!rst_n) return 0;
    if (p == 8) return 8;
    if (p == 0) return step ? 1 : 0;
    if (p == 4 && op == 3'd0 && sticky) return 8;
    return (p + 1) % 8;
  endfunction
  task automatic cyc(input logic [2:0] op, input logic z, input logic st, input logic rn, input bit mr);
    @(posedge clk);
    #1;
    opcode = op; zero = z; step = st; rst_n = rn;
    if (mr) begin
      #1;
      vec++;
      if (!(w1 && w0)) begin err++; $display("FAIL wr_before_reset got %b/%b want 1/1", w1, w0); end
      rst_n = 1'b0;
      #1;
    end
    if (!rst_n) begin p1 = 0; p0 = 0; end
    q1.push_back(model(p1, op, z));
    q0.push_back(model(p0, op, z));
    p1 = next_phase(p1, op, 1'b1);
    p0 = next_phase(p0, op, 1'b0);
  endtask
  function automatic logic rstep();
`ifdef CTRL_STEP_EN
    return ($urandom % 4) != 0;
`else
    return 1'b1;
`endif
  endfunction
  task automatic run_inst(input logic [2:0] op, input int zm);
    bit left = 0;
    logic z;
    for (int i = 0; i < 64; i++) begin
      z = zm == 2 ? 1'($urandom) : zm[0];
      cyc(op, z, rstep(), 1'b1, 1'b0);
      if (p1 != 0) left = 1;
      if ((left && p1 == 0) || p1 == 8) break;
    end
    if (p1 == 8) begin
      repeat (22) cyc(op, 1'($urandom), rstep(), 1'b1, 1'b0);
      repeat (2) cyc(op, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask
  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (q1.size() != 0) begin
      e = q1.pop_front();
      vec++;
      if (v1 !== e) begin err++; $display("FAIL sticky_outputs t=%0t got %b want %b", $time, v1, e); end
    end
    if (q0.size() != 0) begin
      e = q0.pop_front();
      vec++;
      if (v0 !== e) begin err++; $display("FAIL pulse_outputs t=%0t got %b want %b", $time, v0, e); end
    end
  end
  initial begin
    repeat (3) cyc(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(3'd6, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(3'd6, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    run_inst(3'd5, 2);
    run_inst(3'd1, 1);
    run_inst(3'd1, 0);
    run_inst(3'd7, 2);
    run_inst(3'd6, 2);
    run_inst(3'd0, 2);
`ifdef CTRL_STEP_EN
    repeat (10) cyc(3'd2, 1'($urandom), 1'b0, 1'b1, 1'b0);
    cyc(3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (10) cyc(3'd2, 1'($urandom), 1'b0, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 80; i++) run_inst(3'($urandom_range(0, 7)), 2);
    repeat (2) @(negedge clk);
    vec++;
    if (q1.size() != 0 || q0.size() != 0) begin
      err++;
      $display("FAIL queue_drain got %0d/%0d want 0/0", q1.size(), q0.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
